axi4_stream_i2s_tx: RTL and testbench

AXI4_STREAM_I2S_TX -- requirements
Module: axi4_stream_i2s_tx

---
 rtl/audio_stream_pkg.sv | 20 ++
 rtl/axi4_stream_i2s_tx_if.sv | 20 ++
 rtl/i2s_clk_gen.sv | 33 +++
 rtl/axi4_stream_i2s_tx.sv | 126 ++++++++++++
 tb/tb_axi4_stream_i2s_tx.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_stream_pkg.sv
// Shared audio-stream definitions: TLAST channel codes,
// pair-buffer states and I2S frame constants.
package audio_stream_pkg;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        WAIT_L = 2'd0,
        WAIT_R = 2'd1,
        FULL   = 2'd2
    } pair_state_t;

    localparam int I2S_SLOTS = 2;

    function automatic int frame_bits(input int slot_w);
        return I2S_SLOTS * slot_w;
    endfunction

endpackage

// File: rtl/axi4_stream_i2s_tx_if.sv
// AXI4-Stream channel carrying audio samples (TLAST=1 marks right).
// Ports: TVALID, TLAST, TDATA from master; TREADY from slave.
interface axi4_stream_i2s_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;
    logic [DATA_WIDTH-1:0] TDATA;

    modport master (
        output TVALID, TLAST, TDATA,
        input  TREADY
    );

    modport slave (
        input  TVALID, TLAST, TDATA,
        output TREADY
    );
endinterface

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock divider: BCLK toggles every BCLK_DIV ACLK cycles.
// Ports: ACLK, ARESET (sync, high) in; BCLK, fall_stb (1-cycle) out.
module i2s_clk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic ACLK,
    input  logic ARESET,
    output logic BCLK,
    output logic fall_stb
);
    localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BCLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == LAST);

    // Strobe is high in the cycle whose edge drives BCLK low.
    assign fall_stb = wrap && BCLK && !ARESET;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt  <= '0;
            BCLK <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            BCLK <= ~BCLK;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/axi4_stream_i2s_tx.sv
// AXI4-Stream to Philips I2S transmitter with L/R pair buffer.
// Ports: ACLK, ARESET (sync, high); S_AXIS (slave stream);
// I2S_BCLK, I2S_LRCK, I2S_SDATA, UNDERRUN (1-cycle pulse).
// Option: AXI4_STREAM_I2S_TX_REPEAT_EN repeats the last pair on
// underrun instead of sending silence.
module axi4_stream_i2s_tx
    import audio_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    axi4_stream_i2s_tx_if.slave        S_AXIS,
    output logic                       I2S_BCLK,
    output logic                       I2S_LRCK,
    output logic                       I2S_SDATA,
    output logic                       UNDERRUN
);
    localparam int FB    = frame_bits(DATA_WIDTH);
    localparam int CNT_W = $clog2(FB);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FB - 1);
    localparam logic [CNT_W-1:0] SLOT_BITS = CNT_W'(DATA_WIDTH);

    logic                  fall_stb;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_nxt;
    logic [CNT_W-1:0]      bit_nxt_p1;
    logic                  lrck_nxt;
    logic                  load;
    logic [FB-1:0]         shreg;
    logic [FB-1:0]         sh_nxt;
    logic [FB-1:0]         frame;
    pair_state_t           state;
    pair_state_t           st_base;
    pair_state_t           st_nxt;
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
    logic                  tready;
    logic                  accept;
`ifdef AXI4_STREAM_I2S_TX_REPEAT_EN
    logic [FB-1:0]         last_pair;
`endif

    i2s_clk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .BCLK     (I2S_BCLK),
        .fall_stb (fall_stb)
    );

    assign S_AXIS.TREADY = tready;

    always_comb begin
        bit_nxt    = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        bit_nxt_p1 = (bit_nxt == LAST_BIT) ? '0 : bit_nxt + 1'b1;
        // LRCK switches one bit ahead of the slot it names.
        lrck_nxt   = (bit_nxt_p1 >= SLOT_BITS);
        load       = fall_stb && (bit_cnt == LAST_BIT);
        accept     = S_AXIS.TVALID && tready;
`ifdef AXI4_STREAM_I2S_TX_REPEAT_EN
        frame = (state == FULL) ? {left, right} : last_pair;
`else
        frame = (state == FULL) ? {left, right} : '0;
`endif
        sh_nxt = load ? frame : (shreg << 1);
        // Frame load frees the buffer before any beat is applied.
        st_base = (load && state == FULL) ? WAIT_L : state;
        st_nxt  = st_base;
        if (accept) begin
            case (st_base)
                WAIT_L:  if (S_AXIS.TLAST == CH_LEFT)  st_nxt = WAIT_R;
                WAIT_R:  if (S_AXIS.TLAST == CH_RIGHT) st_nxt = FULL;
                default: st_nxt = st_base;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= WAIT_L;
            tready    <= 1'b0;
            bit_cnt   <= LAST_BIT;
            shreg     <= '0;
            left      <= '0;
            right     <= '0;
            I2S_LRCK  <= 1'b0;
            I2S_SDATA <= 1'b0;
            UNDERRUN  <= 1'b0;
`ifdef AXI4_STREAM_I2S_TX_REPEAT_EN
            last_pair <= '0;
`endif
        end else begin
            state    <= st_nxt;
            tready   <= (st_nxt != FULL);
            UNDERRUN <= load && (state != FULL);
            if (fall_stb) begin
                bit_cnt   <= bit_nxt;
                I2S_LRCK  <= lrck_nxt;
                shreg     <= sh_nxt;
                I2S_SDATA <= sh_nxt[FB-1];
            end
`ifdef AXI4_STREAM_I2S_TX_REPEAT_EN
            if (load && state == FULL)
                last_pair <= {left, right};
`endif
            if (accept) begin
                case (st_base)
                    WAIT_L: begin
                        if (S_AXIS.TLAST == CH_LEFT)
                            left <= S_AXIS.TDATA;
                    end
                    WAIT_R: begin
                        if (S_AXIS.TLAST == CH_RIGHT)
                            right <= S_AXIS.TDATA;
                        else
                            left <= S_AXIS.TDATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axi4_stream_i2s_tx.sv
// Self-checking bench for axi4_stream_i2s_tx (32-bit slots, BCLK_DIV 4).
// Cycle-level model of the I2S line plus literal frame expectations.
module tb_axi4_stream_i2s_tx;
    localparam int DW = 32;
    localparam int BD = 4;
    localparam int FB = 2 * DW;
    localparam int BOUND = 6000;
`ifdef AXI4_STREAM_I2S_TX_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bclk, lrck, sdata, und;

    axi4_stream_i2s_tx_if #(.DATA_WIDTH(DW)) s_axis ();

    axi4_stream_i2s_tx #(
        .DATA_WIDTH (DW),
        .BCLK_DIV   (BD)
    ) dut (
        .ACLK      (clk),
        .ARESET    (rst),
        .S_AXIS    (s_axis),
        .I2S_BCLK  (bclk),
        .I2S_LRCK  (lrck),
        .I2S_SDATA (sdata),
        .UNDERRUN  (und)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no event within %0d cycles", name, BOUND);
    endtask

    // Reference model: timeline derived from edge count since reset.
    int          k = 0;
    int          m_b = 0;
    bit          have_left = 0, have_pair = 0;
    logic [31:0] m_left = '0;
    logic [63:0] m_pair = '0, m_last = '0, m_cur = '0;
    logic        e_bclk = 0, e_lrck = 0, e_sd = 0, e_und = 0, e_rdy = 0;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            k = 0; have_left = 0; have_pair = 0;
            m_left = '0; m_pair = '0; m_last = '0; m_cur = '0;
            e_bclk = 0; e_lrck = 0; e_sd = 0; e_und = 0; e_rdy = 0;
        end else begin
            acc = s_axis.TVALID && e_rdy;
            k++;
            e_und = 0;
            e_bclk = ((k / BD) % 2) == 1;
            if (k % (2 * BD) == 0) begin
                m_b = (k / (2 * BD) - 1) % FB;
                if (m_b == 0) begin
                    if (have_pair) begin
                        m_cur = m_pair;
                        m_last = m_pair;
                        have_pair = 0;
                        have_left = 0;
                    end else begin
                        m_cur = REPEAT ? m_last : 64'd0;
                        e_und = 1;
                    end
                end
                e_lrck = ((m_b + 1) % FB) >= DW;
                e_sd = m_cur[FB-1-m_b];
            end
            if (acc) begin
                if (!have_left) begin
                    if (!s_axis.TLAST) begin
                        m_left = s_axis.TDATA;
                        have_left = 1;
                    end
                end else if (s_axis.TLAST) begin
                    m_pair = {m_left, s_axis.TDATA};
                    have_pair = 1;
                end else begin
                    m_left = s_axis.TDATA;
                end
            end
            e_rdy = !have_pair;
        end
    end

    // Per-cycle compare plus a deserializer of the DUT's own line.
    logic [63:0] dut_frames[$];
    bit          dut_und[$];
    int          und_k[$];
    logic [63:0] shin = '0;
    bit          und_at_load = 0;

    always @(negedge clk) begin
        int bb;
        check("bclk", bclk, e_bclk);
        check("lrck", lrck, e_lrck);
        check("sdata", sdata, e_sd);
        check("underrun", und, e_und);
        check("tready", s_axis.TREADY, e_rdy);
        if (und) und_k.push_back(k);
        if (!rst && k > 0 && k % (2 * BD) == 0) begin
            bb = (k / (2 * BD) - 1) % FB;
            if (bb == 0) begin
                shin = '0;
                und_at_load = und;
            end
            shin = {shin[62:0], sdata};
            if (bb == FB - 1) begin
                dut_frames.push_back(shin);
                dut_und.push_back(und_at_load);
            end
        end
    end

    int stalls = 0;

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        s_axis.TVALID = 1'b1;
        s_axis.TDATA = d;
        s_axis.TLAST = l;
        while (!s_axis.TREADY && n < BOUND) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (n >= BOUND) timeout("send");
        @(negedge clk);
    endtask

    task automatic idle();
        s_axis.TVALID = 1'b0;
    endtask

    task automatic find_frame(input logic [63:0] p, input int from,
                              output int idx);
        idx = -1;
        for (int n = 0; n < BOUND && idx < 0; n++) begin
            for (int i = from; i < dut_frames.size(); i++)
                if (idx < 0 && dut_frames[i] == p) idx = i;
            if (idx < 0) @(negedge clk);
        end
        check("frame_found", 64'(idx >= 0), 64'd1);
    endtask

    task automatic wait_frames(input int n);
        int c = 0;
        while (dut_frames.size() < n && c < BOUND) begin
            @(negedge clk);
            c++;
        end
        if (c >= BOUND) timeout("wait_frames");
    endtask

    initial begin
        int base, i;
        logic [63:0] px;
        logic lt;
        s_axis.TVALID = 1'b0;
        s_axis.TLAST = 1'b0;
        s_axis.TDATA = '0;
        repeat (4) @(negedge clk);
        check("tready_in_reset", s_axis.TREADY, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_reset", s_axis.TREADY, 1'b1);

        // Starvation from reset: silent frames, underrun each 512.
        wait_frames(2);
        check("starve_f0", dut_frames[0], 64'd0);
        check("starve_f1", dut_frames[1], 64'd0);
        check("starve_u0", dut_und[0], 1'b1);
        check("starve_u1", dut_und[1], 1'b1);
        check("und_first_k", und_k[0], 8);
        check("und_period", und_k[1] - und_k[0], 512);

        // Single pair with both extreme bits set.
        base = dut_frames.size();
        send(32'h8000_0001, 1'b0);
        send(32'h7FFF_FFFE, 1'b1);
        idle();
        find_frame(64'h8000_0001_7FFF_FFFE, base, i);
        if (i >= 0) check("pair_no_und", dut_und[i], 1'b0);

        // Resync: stray right dropped, second left overwrites first.
        base = dut_frames.size();
        send(32'h1111_1111, 1'b1);
        send(32'hAAAA_AAAA, 1'b0);
        send(32'h5555_5555, 1'b0);
        send(32'h3333_3333, 1'b1);
        idle();
        find_frame(64'h5555_5555_3333_3333, base, i);
        if (i >= 0) check("resync_no_und", dut_und[i], 1'b0);

        // Back-to-back pairs under continuous TVALID.
        base = dut_frames.size();
        stalls = 0;
        send(32'hA1A1_0001, 1'b0);
        send(32'hB1B1_0001, 1'b1);
        send(32'hA2A2_0002, 1'b0);
        send(32'hB2B2_0002, 1'b1);
        send(32'hA3A3_0003, 1'b0);
        send(32'hB3B3_0003, 1'b1);
        idle();
        check("backpressure_seen", 64'(stalls > 0), 64'd1);
        find_frame(64'hA1A1_0001_B1B1_0001, base, i);
        if (i >= 0) begin
            wait_frames(i + 3);
            check("burst_p2", dut_frames[i+1], 64'hA2A2_0002_B2B2_0002);
            check("burst_p3", dut_frames[i+2], 64'hA3A3_0003_B3B3_0003);
            check("burst_und", {dut_und[i], dut_und[i+1], dut_und[i+2]},
                  64'd0);
        end

        // Starvation after a pair: repeat or silence.
        base = dut_frames.size();
        send(32'h1234_5678, 1'b0);
        send(32'h9ABC_DEF0, 1'b1);
        idle();
        find_frame(64'h1234_5678_9ABC_DEF0, base, i);
        if (i >= 0) begin
            wait_frames(i + 2);
            check("repeat_frame", dut_frames[i+1],
                  REPEAT ? 64'h1234_5678_9ABC_DEF0 : 64'd0);
            check("repeat_und", dut_und[i+1], 1'b1);
        end

        // Random traffic, mostly alternating with occasional slips.
        lt = 1'b1;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            lt = ($urandom_range(0, 99) < 15) ? lt : ~lt;
            send($urandom, lt);
            idle();
        end
        wait_frames(dut_frames.size() + 2);

        // Reset in the middle of a frame with a half pair pending.
        px = 64'hC3C3_3C3C_0F0F_F0F0;
        send(px[63:32], 1'b0);
        send(px[31:0], 1'b1);
        send(32'hDEAD_BEEF, 1'b0);
        idle();
        i = 0;
        while (!(k % (2 * BD) == 0 && m_b == 40 && m_cur == px)
               && i < BOUND) begin
            @(negedge clk);
            i++;
        end
        if (i >= BOUND) timeout("reach_bit40");
        rst = 1'b1;
        @(negedge clk);
        check("rst_bclk", bclk, 1'b0);
        check("rst_lrck", lrck, 1'b0);
        check("rst_sdata", sdata, 1'b0);
        check("rst_und", und, 1'b0);
        check("rst_tready", s_axis.TREADY, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = dut_frames.size();
        wait_frames(base + 1);
        check("post_rst_frame", dut_frames[base], 64'd0);
        check("post_rst_und", dut_und[base], 1'b1);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
